// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs it into 32-bit words,
// writes them to instruction memory and holds the core in reset until the image is complete.
module program_loader #(
   parameter int MAX_WORDS = 256,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             im_we,
   output logic [31:0]      im_addr,
   output logic [31:0]      im_wdata,
   output logic             cpu_rst,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   logic [7:0]       hdr_hi;
   logic [CNT_W-1:0] count;
   logic [31:0]      word;
   logic [1:0]       idx;

   logic             accept;
   logic [15:0]      hdr_val;
   logic             hdr_bad;
   logic [CNT_W-1:0] wl_next;

   assign accept  = byte_valid && byte_ready;
   assign hdr_val = {hdr_hi, byte_in};
   assign hdr_bad = (hdr_val == 16'd0) || (32'(hdr_val) > 32'(MAX_WORDS));
   assign wl_next = words_loaded + CNT_W'(1);

   // Outputs are registered together with the state so each one is a pure function of state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         byte_ready   <= 1'b0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_wdata     <= '0;
         cpu_rst      <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         hdr_hi       <= '0;
         count        <= '0;
         word         <= '0;
         idx          <= '0;
      end else begin
         im_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state        <= S_HDR_HI;
                  byte_ready   <= 1'b1;
                  cpu_rst      <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= '0;
               end
            end
            S_HDR_HI: begin
               if (accept) begin
                  hdr_hi <= byte_in;
                  state  <= S_HDR_LO;
               end
            end
            S_HDR_LO: begin
               if (accept) begin
                  count <= CNT_W'(hdr_val);
                  if (hdr_bad) begin
                     state      <= S_ERROR;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                  end else begin
                     state <= S_DATA;
                     idx   <= '0;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  word <= {word[23:0], byte_in};
                  idx  <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     state      <= S_WRITE;
                     byte_ready <= 1'b0;
                     im_we      <= 1'b1;
                     im_wdata   <= {word[23:0], byte_in};
                     im_addr    <= 32'(words_loaded) << 2;
                  end
               end
            end
            S_WRITE: begin
               words_loaded <= wl_next;
               if (wl_next == count) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
               end else begin
                  state      <= S_DATA;
                  byte_ready <= 1'b1;
                  idx        <= '0;
               end
            end
            default: begin
               state      <= S_IDLE;
               byte_ready <= 1'b0;
               cpu_rst    <= 1'b1;
               done       <= 1'b0;
               error      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the single-cycle RISC core.
- Receives a program image as a byte stream over a valid/ready handshake and packs the bytes into 32-bit instructions.
- Writes each instruction into instruction memory at consecutive byte addresses (0, 4, 8, ...).
- Holds the core in reset until the whole image is written. On a bad header it stays in an error state and keeps the core in reset.

Parameters:
- MAX_WORDS, 256, maximum number of instructions accepted; a header count above this is an error.
- CNT_W, 16, width of the header word count and of words_loaded.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction memory write enable, one cycle per word.
- im_addr  output  32  instruction memory byte address.
- im_wdata  output  32  instruction word to write.
- cpu_rst  output  1  reset to core; high except in DONE.
- done  output  1  image fully loaded (level, high in DONE).
- error  output  1  header rejected (level, high in ERROR).
- words_loaded  output  CNT_W  count of words written in the current load.

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IDLE;
  - cpu_rst = 1;
  - byte_ready, im_we, done and error = 0;
  - im_addr, im_wdata and words_loaded = 0;
  - byte assembly and header registers cleared.
- Transfer rule: a byte is accepted only on a cycle with byte_valid && byte_ready. byte_valid while byte_ready = 0 is ignored, and no byte is consumed.
- Image format:
  - header byte 0 = count[15:8], header byte 1 = count[7:0];
  - then count words, 4 bytes each, most significant byte first.
- States:
  - IDLE: byte_ready = 0. start -> HDR_HI; words_loaded cleared.
  - HDR_HI: byte_ready = 1. On accept, latch the high count byte -> HDR_LO.
  - HDR_LO: byte_ready = 1. On accept, latch the low count byte and evaluate the full count. If count == 0 or count > MAX_WORDS -> ERROR; else -> DATA with byte index 0.
  - DATA: byte_ready = 1. Each accept shifts the byte into the assembly register (word = {word[23:0], byte_in}) and increments the byte index 0..3. The accept at index 3 -> WRITE.
  - WRITE: one cycle; byte_ready = 0; im_we = 1; im_wdata = assembled word; im_addr = words_loaded << 2. On the next edge words_loaded increments. If the new value == count -> DONE, else -> DATA with byte index 0.
  - DONE: cpu_rst = 0; done = 1; byte_ready = 0. start -> HDR_HI; on that edge cpu_rst returns to 1 and done to 0.
  - ERROR: error = 1; cpu_rst = 1; byte_ready = 0. start -> HDR_HI; error clears.
- start in HDR_HI, HDR_LO, DATA or WRITE is ignored.
- Output timing:
  - All outputs are registered or decoded from state only; no combinational path from byte_valid to any output.
  - byte_ready depends only on state.
  - im_we is high only in WRITE, never for two consecutive cycles.
- Latency:
  - The last byte of word k is accepted on cycle t; im_we for word k is high on cycle t+1.
  - The earliest next accept is cycle t+2.
  - Minimum cycles per word is 5.
- im_addr and im_wdata hold their last written values outside WRITE.
- Arithmetic:
  - im_addr is the zero-extension of words_loaded shifted left by 2.
  - words_loaded never exceeds count, so it does not wrap.
- Reset mid-load: asynchronous return to IDLE with the reset values above. Partial words are discarded, and memory contents already written are left untouched.
- Simultaneous events:
  - rst overrides everything.
  - A byte presented in the same cycle as start in IDLE is not accepted, because byte_ready = 0 in that cycle.

Test Plan:
- rst pulse mid-DATA (after 2 bytes of word 1) -> immediate state IDLE, cpu_rst = 1, words_loaded = 0, byte_ready = 0; a subsequent start and full image load correctly from address 0.
- start, stream 00 02 | 20 01 00 05 | 8C 22 00 04 with byte_valid always 1 -> im_we twice, at (addr 0, data 32'h20010005) and (addr 4, data 32'h8C220004); then done = 1, cpu_rst = 0, words_loaded = 2.
- Same image with byte_valid toggling 1/0 every cycle -> identical writes and final state; no byte is dropped or duplicated, and byte_ready = 0 during each WRITE cycle.
- Header 00 00 -> ERROR: error = 1, cpu_rst = 1, no im_we. Header 01 01 (257 > 256) -> ERROR likewise. Then start plus a valid image -> error clears and the load completes.
- After DONE, pulse start and load a 1-word image DE AD BE EF -> cpu_rst rises on the start edge, write at addr 0 with 32'hDEADBEEF, then done = 1 and words_loaded = 1.
- start held high during DATA -> ignored; load completes normally with the correct count.
